// File: rtl/serial_frame_receiver_pkg.sv
// Shared constants and state encoding for the serial frame receiver.
// The default frame format is a 4-bit sync followed by two 4-bit words, each with an even-parity bit.
package serial_frame_receiver_pkg;

  localparam int              DEF_WIDTH       = 4;
  localparam int              DEF_SYNC_W      = 4;
  localparam logic [3:0]      DEF_SYNC        = 4'b1011;
  localparam int              DEF_FRAME_WORDS = 2;
  localparam logic            DIR_MSB_FIRST   = 1'b1;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Bit-stream input and buffered-word output of the serial frame receiver.
// Signal suffixes are named from the receiver's side.
interface serial_frame_receiver_if
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             enb_i;
  logic             dir_i;
  logic             sIn_i;
  logic             rd_i;
  logic [WIDTH-1:0] qOut_o;
  logic             parErr_o;
  logic             valid_o;
  logic             lock_o;
  logic             ovf_o;
  logic [1:0]       count_o;

  modport master (
    output enb_i, dir_i, sIn_i, rd_i,
    input  qOut_o, parErr_o, valid_o, lock_o, ovf_o, count_o
  );

  modport slave (
    input  enb_i, dir_i, sIn_i, rd_i,
    output qOut_o, parErr_o, valid_o, lock_o, ovf_o, count_o
  );

endinterface

// File: rtl/serial_frame_receiver_fifo2.sv
// Two-entry FIFO. The head entry always sits in e0_q, so the output is a plain register that reads 0 when empty.
module serial_frame_receiver_fifo2 #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o,
  output logic          ovf_o
);

  logic [DW-1:0] e0_q;
  logic [DW-1:0] e1_q;
  logic [1:0]    count_q;
  logic          ovf_q;
  logic          doPop;
  logic          doPush;

  // A push into a full buffer still lands if the head leaves on the same edge.
  assign doPop  = pop_i && (count_q != 2'd0);
  assign doPush = push_i && ((count_q != 2'd2) || doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_i && !doPush) begin
        ovf_q <= 1'b1;
      end
      case (count_q)
        2'd0: begin
          if (doPush) begin
            e0_q    <= pushData_i;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (doPop && doPush) begin
            e0_q <= pushData_i;
          end else if (doPop) begin
            e0_q    <= '0;
            count_q <= 2'd0;
          end else if (doPush) begin
            e1_q    <= pushData_i;
            count_q <= 2'd2;
          end
        end
        default: begin
          if (doPop) begin
            e0_q <= e1_q;
            if (doPush) begin
              e1_q <= pushData_i;
            end else begin
              e1_q    <= '0;
              count_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Hunts a serial stream for the sync pattern, then assembles parity-checked words into a two-entry buffer.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC       = DEF_SYNC,
  parameter int               FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_receiver_if.slave  bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = WIDTH + 1;

  state_t            state_q;
  logic [SYNC_W-1:0] win_q;
  logic [SYNC_W-1:0] win_d;
  logic [WIDTH-1:0]  sh_q;
  logic [WIDTH-1:0]  sh_d;
  logic [BW-1:0]     bitCnt_q;
  logic [7:0]        wordCnt_q;
  logic              dir_q;
  logic              lock_q;
  logic              perr;
  logic              push;
  logic              frameDone;
  logic [DW-1:0]     head;

  always_comb begin
    win_d     = {win_q[SYNC_W-2:0], bus.sIn_i};
    sh_d      = (dir_q == DIR_MSB_FIRST) ? {sh_q[WIDTH-2:0], bus.sIn_i}
                                         : {bus.sIn_i, sh_q[WIDTH-1:1]};
    perr      = ^{sh_q, bus.sIn_i};
    push      = bus.enb_i && (state_q == ST_PAR);
    frameDone = perr || ((wordCnt_q + 8'd1) == 8'(FRAME_WORDS));
  end

  // Returning to HUNT clears the window so leftover data bits cannot complete a false sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      win_q     <= '0;
      sh_q      <= '0;
      bitCnt_q  <= '0;
      wordCnt_q <= 8'd0;
      dir_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else if (bus.enb_i) begin
      case (state_q)
        ST_HUNT: begin
          win_q <= win_d;
          if (win_d == SYNC) begin
            state_q   <= ST_DATA;
            lock_q    <= 1'b1;
            bitCnt_q  <= '0;
            wordCnt_q <= 8'd0;
            dir_q     <= bus.dir_i;
          end
        end
        ST_DATA: begin
          sh_q <= sh_d;
          if (bitCnt_q == BW'(WIDTH - 1)) begin
            state_q  <= ST_PAR;
            bitCnt_q <= '0;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        ST_PAR: begin
          wordCnt_q <= wordCnt_q + 8'd1;
          if (frameDone) begin
            state_q <= ST_HUNT;
            lock_q  <= 1'b0;
            win_q   <= '0;
          end else begin
            state_q <= ST_DATA;
          end
        end
        default: begin
          state_q <= ST_HUNT;
          lock_q  <= 1'b0;
          win_q   <= '0;
        end
      endcase
    end
  end

  serial_frame_receiver_fifo2 #(
    .DW(DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushData_i ({sh_q, perr}),
    .pop_i      (bus.rd_i),
    .head_o     (head),
    .count_o    (bus.count_o),
    .ovf_o      (bus.ovf_o)
  );

  assign bus.qOut_o   = head[DW-1:1];
  assign bus.parErr_o = head[0];
  assign bus.valid_o  = (bus.count_o != 2'd0);
  assign bus.lock_o   = lock_q;

endmodule
